// File: rtl/invsqrt_pkg.sv
// Shared definitions for the inverse-square-root bus initiator:
// bus register map, STATUS field positions, controller state encoding
// and the count saturation helper used when packing STATUS.
package invsqrt_pkg;

  localparam logic [1:0] ADDR_OPERAND = 2'd0;
  localparam logic [1:0] ADDR_RESULT  = 2'd1;
  localparam logic [1:0] ADDR_STATUS  = 2'd2;
  localparam logic [1:0] ADDR_CTRL    = 2'd3;

  localparam int unsigned ST_CMD_LSB = 0;
  localparam int unsigned ST_RES_LSB = 3;
  localparam int unsigned ST_BUSY    = 6;
  localparam int unsigned ST_OVF     = 7;
  localparam int unsigned ST_UDF     = 8;

  localparam int unsigned CTRL_FLUSH_BIT = 0;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_t;

  // STATUS count fields are 3 bits wide; deeper FIFOs report 7.
  function automatic logic [2:0] sat_count(input int unsigned n);
    return (n > 7) ? 3'd7 : n[2:0];
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with flush.
//   clk, rst      clock, asynchronous active-high reset
//   flush         empties the FIFO (overrides push/pop in that cycle)
//   push, wdata   write request and data; accepted when not full, or when
//                 a pop happens in the same cycle
//   pop, rdata    read request; rdata always shows the head entry
//   full, empty   occupancy flags
//   count         number of stored entries
module sync_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == CW'(DEPTH));
  assign count   = cnt;
  assign rdata   = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      cnt <= cnt + CW'(1);
      else if (do_pop && !do_push) cnt <= cnt - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/invsqrt_initiator.sv
// Bus-facing initiator for the fixed-point inverse square root core.
// Operands written to OPERAND queue in a command FIFO and are issued to the
// core one at a time; results are collected into a result FIFO read back
// through RESULT.
//   clk, rst                      clock, asynchronous active-high reset
//   bus_we/bus_re/bus_addr        single-cycle bus strobes and register select
//   bus_wdata, bus_rdata          write data, registered read data
//   core_data, core_valid         operand channel to the core
//   core_ready                    core can take an operand
//   core_result(_valid/_ready)    result channel from the core
//   irq                           result FIFO non-empty
module invsqrt_initiator
  import invsqrt_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bus_we,
  input  logic             bus_re,
  input  logic [1:0]       bus_addr,
  input  logic [WIDTH-1:0] bus_wdata,
  output logic [WIDTH-1:0] bus_rdata,
  output logic [WIDTH-1:0] core_data,
  output logic             core_valid,
  input  logic             core_ready,
  input  logic [WIDTH-1:0] core_result,
  input  logic             core_result_valid,
  output logic             core_result_ready,
  output logic             irq
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  state_t state;
  state_t state_nxt;

  logic             ovf;
  logic             udf;
  logic             discard;

  logic             flush;
  logic             cmd_push;
  logic             cmd_pop;
  logic [WIDTH-1:0] cmd_head;
  logic             cmd_full;
  logic             cmd_empty;
  logic [CW-1:0]    cmd_count;

  logic             res_push;
  logic             res_pop;
  logic             res_rd;
  logic [WIDTH-1:0] res_head;
  logic             res_full;
  logic             res_empty;
  logic [CW-1:0]    res_count;

  logic             core_hs;
  logic             res_accept;
  logic [WIDTH-1:0] status;

  assign flush      = bus_we && (bus_addr == ADDR_CTRL) && bus_wdata[CTRL_FLUSH_BIT];
  assign cmd_push   = bus_we && (bus_addr == ADDR_OPERAND);
  assign res_rd     = bus_re && (bus_addr == ADDR_RESULT);
  assign res_pop    = res_rd && !res_empty;
  assign core_hs    = (state == ISSUE) && core_ready;
  assign res_accept = (state == WAIT) && core_result_valid && !res_full;
  assign res_push   = res_accept && !discard;
  assign irq        = !res_empty;

  sync_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_cmd_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (cmd_push),
    .wdata (bus_wdata),
    .pop   (cmd_pop),
    .rdata (cmd_head),
    .full  (cmd_full),
    .empty (cmd_empty),
    .count (cmd_count)
  );

  sync_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_res_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (res_push),
    .wdata (core_result),
    .pop   (res_pop),
    .rdata (res_head),
    .full  (res_full),
    .empty (res_empty),
    .count (res_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // A flush in ISSUE without a handshake abandons the operand before the
  // core ever saw it, so the FSM simply falls back to IDLE.
  always_comb begin
    state_nxt         = state;
    cmd_pop           = 1'b0;
    core_valid        = 1'b0;
    core_result_ready = 1'b0;
    case (state)
      IDLE: begin
        if (!cmd_empty && !flush) begin
          cmd_pop   = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        core_valid = 1'b1;
        if (core_hs)    state_nxt = WAIT;
        else if (flush) state_nxt = IDLE;
      end
      WAIT: begin
        core_result_ready = !res_full;
        if (res_accept) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // discard marks a result still owed by the core whose operand was flushed.
  // A result arriving in the same cycle as the flush is already swallowed by
  // the FIFO flush, so nothing is left outstanding in that case.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf     <= 1'b0;
      udf     <= 1'b0;
      discard <= 1'b0;
    end else begin
      if (flush) begin
        ovf     <= 1'b0;
        udf     <= 1'b0;
        discard <= ((state == WAIT) && !res_accept) || core_hs;
      end else begin
        if (cmd_push && cmd_full && !cmd_pop) ovf <= 1'b1;
        if (res_rd && res_empty)              udf <= 1'b1;
        if (res_accept)                       discard <= 1'b0;
      end
    end
  end

  always_comb begin
    status                      = '0;
    status[ST_CMD_LSB +: 3]     = sat_count(32'(cmd_count));
    status[ST_RES_LSB +: 3]     = sat_count(32'(res_count));
    status[ST_BUSY]             = (state != IDLE);
    status[ST_OVF]              = ovf;
    status[ST_UDF]              = udf;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      core_data <= '0;
      bus_rdata <= '0;
    end else begin
      if (cmd_pop) core_data <= cmd_head;
      if (bus_re) begin
        case (bus_addr)
          ADDR_RESULT: bus_rdata <= res_empty ? '0 : res_head;
          ADDR_STATUS: bus_rdata <= status;
          default:     bus_rdata <= '0;
        endcase
      end
    end
  end

endmodule
